// File: rtl/bcdcount_chain.sv
// Chained radix-RADIX decimal counter with parallel load, BCD and ASCII-offset views.
// Define BCDCOUNT_DOWN_EN to enable down counting selected by dir.
module bcdcount_chain #(
    parameter int         DIGITS = 4,
    parameter int         RADIX  = 10,
    parameter logic [7:0] BASE   = 8'h30
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [DIGITS*4-1:0]   load_val,
    input  logic                  dir,
    output logic [DIGITS*4-1:0]   bcd,
    output logic [DIGITS*8-1:0]   digits,
    output logic                  carry,
    output logic                  zero
);

    localparam logic [3:0] MAX = 4'(RADIX - 1);

    logic [DIGITS-1:0][3:0] dig_q;
    logic [DIGITS-1:0][3:0] dig_d;
    logic                   carry_q;
    logic                   carry_d;

`ifndef BCDCOUNT_DOWN_EN
    logic unused_dir;
    assign unused_dir = dir;
`endif

    always_comb begin
        logic ripple;
        dig_d   = dig_q;
        carry_d = 1'b0;
        ripple  = 1'b1;
        if (load) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (load_val[4*i +: 4] > MAX) begin
                    dig_d[i] = MAX;
                end else begin
                    dig_d[i] = load_val[4*i +: 4];
                end
            end
        end else if (en) begin
            // ripple stays high while every lower digit sits at its wrap value
            for (int i = 0; i < DIGITS; i++) begin
`ifdef BCDCOUNT_DOWN_EN
                if (dir) begin
                    if (ripple) begin
                        dig_d[i] = (dig_q[i] == 4'd0) ? MAX : dig_q[i] - 4'd1;
                    end
                    ripple = ripple & (dig_q[i] == 4'd0);
                end else begin
`endif
                    if (ripple) begin
                        dig_d[i] = (dig_q[i] == MAX) ? 4'd0 : dig_q[i] + 4'd1;
                    end
                    ripple = ripple & (dig_q[i] == MAX);
`ifdef BCDCOUNT_DOWN_EN
                end
`endif
            end
            carry_d = ripple;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            dig_q   <= dig_d;
            carry_q <= carry_d;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_ascii
        assign digits[8*g +: 8] = BASE + {4'b0000, dig_q[g]};
    end

    assign bcd   = dig_q;
    assign carry = carry_q;
    assign zero  = (dig_q == '0);

endmodule

// File: tb/tb_bcdcount_chain.sv
// Scoreboard bench for bcdcount_chain: a 2-digit decimal instance and a 1-digit radix-6 instance.
module tb_bcdcount_chain;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic        dir = 1'b0;
    logic [7:0]  load_val = 8'h00;
    logic [7:0]  bcd;
    logic [15:0] digits;
    logic        carry;
    logic        zero;

    logic        en6 = 1'b0;
    logic [3:0]  bcd6;
    logic [7:0]  digits6;
    logic        carry6;
    logic        zero6;

    typedef struct {
        bit          sel;
        logic [7:0]  bcd;
        logic        carry;
        logic        zero;
        logic [15:0] digits;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    event chk_ev;

    always #5 clk = ~clk;

    bcdcount_chain #(.DIGITS(2), .RADIX(10), .BASE(8'h30)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .load_val(load_val), .dir(dir), .bcd(bcd),
        .digits(digits), .carry(carry), .zero(zero)
    );

    bcdcount_chain #(.DIGITS(1), .RADIX(6), .BASE(8'h30)) dut6 (
        .clk(clk), .rst(rst), .en(en6), .load(1'b0),
        .load_val(4'h0), .dir(1'b0), .bcd(bcd6),
        .digits(digits6), .carry(carry6), .zero(zero6)
    );

    task automatic cmp(string nm, string fld, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    function automatic void push(bit sel, logic [7:0] b, logic c, logic z, string nm);
        exp_t e;
        e.sel   = sel;
        e.bcd   = b;
        e.carry = c;
        e.zero  = z;
        if (sel) e.digits = {8'h00, 8'h30 + {4'h0, b[3:0]}};
        else     e.digits = {8'h30 + {4'h0, b[7:4]}, 8'h30 + {4'h0, b[3:0]}};
        e.name  = nm;
        q.push_back(e);
    endfunction

    // Monitor: one expectation per clock edge or explicit async check.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.sel) begin
                    cmp(e.name, "bcd", {12'h0, bcd6}, {8'h0, e.bcd});
                    cmp(e.name, "carry", {15'h0, carry6}, {15'h0, e.carry});
                    cmp(e.name, "zero", {15'h0, zero6}, {15'h0, e.zero});
                    cmp(e.name, "digits", {8'h0, digits6}, e.digits);
                end else begin
                    cmp(e.name, "bcd", {8'h0, bcd}, {8'h0, e.bcd});
                    cmp(e.name, "carry", {15'h0, carry}, {15'h0, e.carry});
                    cmp(e.name, "zero", {15'h0, zero}, {15'h0, e.zero});
                    cmp(e.name, "digits", digits, e.digits);
                end
            end
        end
    end

    task automatic step(logic l, logic [7:0] lv, logic e, logic d,
                        logic [7:0] b, logic c, logic z, string nm);
        @(negedge clk);
        load     = l;
        load_val = lv;
        en       = e;
        dir      = d;
        en6      = 1'b0;
        push(1'b0, b, c, z, nm);
    endtask

    task automatic step6(logic e, logic [7:0] b, logic c, logic z, string nm);
        @(negedge clk);
        load = 1'b0;
        en   = 1'b0;
        en6  = e;
        push(1'b1, b, c, z, nm);
    endtask

    initial begin
        logic [7:0] v;
        #2;
        push(1'b0, 8'h00, 1'b0, 1'b1, "reset");
        push(1'b1, 8'h00, 1'b0, 1'b1, "reset6");
        ->chk_ev;
        #3;
        ->chk_ev;
        @(negedge clk);
        rst = 1'b0;

        for (int k = 1; k <= 100; k++) begin
            v = 8'((k % 100) / 10) << 4 | 8'((k % 100) % 10);
            step(1'b0, 8'h00, 1'b1, 1'b0, v, k == 100, (k % 100) == 0, "run");
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "hold");

        step(1'b1, 8'h09, 1'b0, 1'b0, 8'h09, 1'b0, 1'b0, "load09");
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0, "ripple10");
        step(1'b1, 8'h99, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0, "load99");
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, "wrap");
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "carry_drop");

        step(1'b1, 8'hAF, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0, "sat_af");
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, "wrap2");
        step(1'b1, 8'h5A, 1'b1, 1'b0, 8'h59, 1'b0, 1'b0, "load_over_en");

        step(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "load00");
`ifdef BCDCOUNT_DOWN_EN
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h99, 1'b1, 1'b0, "down99");
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h98, 1'b0, 1'b0, "down98");
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h97, 1'b0, 1'b0, "down97");
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h98, 1'b0, 1'b0, "up_again");
`else
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, "dir_ign1");
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0, "dir_ign2");
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, "dir_ign3");
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0, "dir_up");
`endif

        step(1'b1, 8'h57, 1'b0, 1'b0, 8'h57, 1'b0, 1'b0, "load57");
        @(posedge clk);
        #2;
        rst = 1'b1;
        push(1'b0, 8'h00, 1'b0, 1'b1, "async_rst");
        ->chk_ev;
        #2;
        rst = 1'b0;
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, "post_rst");
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, "post_hold");

        for (int k = 1; k <= 13; k++) begin
            v = 8'(k % 6);
            step6(1'b1, v, (k % 6) == 0, (k % 6) == 0, "r6");
        end
        step6(1'b0, 8'h01, 1'b0, 1'b0, "r6_hold");

        @(negedge clk);
        en  = 1'b0;
        en6 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
